wb_queue: RTL

- Writeback buffer that owns the write side of the integer register file.
- Accepts results from execute/memory units over a valid/ready handshake and queues them in order.
- Drains one entry per cycle into the register-file write port (rd, rd_in, rd_w) whenever the port is not stalled.
- Provides combinational lookup of pending results so the decode stage can bypass values not yet committed to the register file.

---
 rtl/wb_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback buffer feeding the integer register file write
// port, with combinational bypass lookup of results not yet committed.
module wb_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     wb_stall,
  output logic                     rd_w,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          rd_in,
  input  logic [4:0]               q_rs1,
  output logic                     q_rs1_hit,
  output logic [XLEN-1:0]          q_rs1_data,
  input  logic [4:0]               q_rs2,
  output logic                     q_rs2_hit,
  output logic [XLEN-1:0]          q_rs2_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;

  logic full, empty, push, pop;

  // Handshake, drain and head presentation
  always_comb begin
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    in_ready = !full;
    // x0 results complete the handshake but are never stored
    push     = in_valid && in_ready && (in_rd != '0);
    pop      = !empty && !wb_stall;
    rd_w     = pop;
    rd       = empty ? '0 : rd_mem_q[head_q];
    rd_in    = empty ? '0 : data_mem_q[head_q];
    level    = level_q;
  end

  // Next-state for pointers and occupancy
  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards pending entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  // Entry storage; contents are only observed while counted in level
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[tail_q]   <= in_rd;
      data_mem_q[tail_q] <= in_data;
    end
  end

  // Bypass lookup: scanning oldest to newest and letting later matches
  // overwrite earlier ones yields the newest-first priority
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    q_rs1_hit  = 1'b0;
    q_rs1_data = '0;
    q_rs2_hit  = 1'b0;
    q_rs2_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (LW'(i) < level_q) begin
        if ((q_rs1 != '0) && (rd_mem_q[idx] == q_rs1)) begin
          q_rs1_hit  = 1'b1;
          q_rs1_data = data_mem_q[idx];
        end
        if ((q_rs2 != '0) && (rd_mem_q[idx] == q_rs2)) begin
          q_rs2_hit  = 1'b1;
          q_rs2_data = data_mem_q[idx];
        end
      end
    end
  end

endmodule
